cargador_instrucciones: RTL and testbench
=========================================

# cargador_instrucciones

Boot-time program loader; the write side of the instruction memory that the single-cycle core fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It holds the core in reset until a complete frame with a correct checksum has been written, then releases it.

## Interface
Parameters:
- `ADDR_W`, 6: instruction-memory word-address width.
- `DEPTH`, 64: maximum number of words per frame; must be ≤ 2^ADDR_W and ≤ 255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `byte_valid`  in  1  source presents `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader can accept a byte. Registered.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  instruction word to write.
- `cpu_reset`  out  1  active-low reset to the core. It is 0 (core held in reset) until the load completes.
- `done`  out  1  frame loaded and verified. Sticky until reset.
- `err`  out  1  frame rejected. Sticky until reset.

## Operation
- A byte is accepted on any edge where `byte_valid & byte_ready`. Non-accepted cycles change nothing.
- Frame format:
  - count byte N;
  - then 4·N data bytes, most significant byte first (byte 0 goes to [31:24]);
  - then one checksum byte, equal to the XOR of N and all data bytes.
- States:
  - `S_CNT`: waits for the count byte. If N = 0 or N > DEPTH, go to `S_ERR`. Otherwise latch N, set chk = N, clear the word index and byte index, and go to `S_DAT`.
  - `S_DAT`: each accepted byte is shifted into a 32-bit assembly register and XORed into chk, and the 2-bit byte index increments. On the 4th byte of a word:
    - the next cycle asserts `mem_we` with `mem_addr` = word index and `mem_wdata` = the assembled word;
    - the word index increments after that write.
    - After the 4th byte of word N−1, go to `S_CHK`.
  - `S_CHK`: the next accepted byte is compared with chk. Equal → `S_DONE`; unequal → `S_ERR`.
  - `S_DONE`: `done` = 1, `cpu_reset` = 1, `byte_ready` = 0. Leaves only on reset.
  - `S_ERR`: `err` = 1, `cpu_reset` = 0, `byte_ready` = 0. Leaves only on reset. Words already written stay in memory.
- `byte_ready` is registered from the next state: 1 exactly when the next state is `S_CNT`, `S_DAT` or `S_CHK`. No byte is ever accepted in `S_DONE` or `S_ERR`.
- Widths:
  - chk is 8 bits.
  - The word index is ADDR_W+1 bits internally, so that N = DEPTH = 2^ADDR_W can be counted. `mem_addr` is its low ADDR_W bits.
  - Addresses never wrap within a legal frame.

## Timing
- While `reset` = 0 at an edge:
  - state ← `S_CNT`; all indices, chk and the assembly register ← 0;
  - `byte_ready` ← 0, `mem_we` ← 0, `mem_addr` ← 0, `mem_wdata` ← 0;
  - `cpu_reset` ← 0, `done` ← 0, `err` ← 0.
- `byte_ready` rises on the first edge with `reset` = 1.
- Throughput: one byte per cycle sustained. The core writes word k one cycle after its 4th byte and does not stall the stream.
- The checksum byte may be accepted in the same cycle as the last `mem_we` pulse.
- `done`, `cpu_reset` rise and `byte_ready` falls one cycle after the checksum byte is accepted. `err` asserts one cycle after the offending byte.
- Reset in mid-frame aborts immediately:
  - a partially assembled word is discarded with no write;
  - a `mem_we` pulse scheduled for the reset edge is suppressed;
  - the next frame starts again at address 0.
- `mem_we` is never high for two consecutive cycles.

## Test plan
- Single word: N = 0x01, bytes 0x20,0x08,0x00,0x05, chk 0x2C → exactly one `mem_we` pulse with addr 0 and data 0x20080005; `done` = 1, `cpu_reset` = 1 one cycle after the chk byte; `err` = 0.
- Full frame: N = 64, 256 back-to-back random bytes, correct chk → 64 writes at addresses 0..63 with the correct words; no backpressure gaps; `done` = 1; `byte_ready` = 0 afterwards, and further `byte_valid` pulses are ignored.
- Bad count: N = 0x00, and separately N = 0x41 → `err` = 1 the next cycle, no `mem_we`, `cpu_reset` stays 0.
- Checksum mismatch: the single-word frame with chk 0x2D → the write at addr 0 occurs, then `err` = 1, `done` = 0, `cpu_reset` = 0.
- Bubbles: the 2-word frame with `byte_valid` toggling randomly → same writes and `done` as the gap-free case; bytes are counted only on valid&ready.
- Mid-frame reset: assert `reset` = 0 after the 6th data byte of a 3-word frame, then send a correct 1-word frame → no write for the partial word 1; the new word goes to addr 0; `done` = 1.

Source files
------------

// File: rtl/cargador_instrucciones.sv
// Boot-time program loader: assembles a framed, checksummed byte stream into
// big-endian 32-bit words, writes them to instruction memory and then releases the core.
module cargador_instrucciones #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    // Comparison width wide enough for both the 8-bit count and the word index.
    localparam int CW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_CNT,
        S_DAT,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        chk;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       asm_word;

    logic              accept;
    logic              last_word;
    logic              active;
    logic [CW-1:0]     widx_ext;
    logic [CW-1:0]     cnt_ext;
    logic [31:0]       asm_next;

    assign accept    = byte_valid & byte_ready;
    assign widx_ext  = CW'(word_idx);
    assign cnt_ext   = CW'(cnt);
    assign last_word = ((widx_ext + CW'(1)) == cnt_ext);
    assign asm_next  = {asm_word[23:0], byte_data};
    assign active    = (state == S_CNT) || (state == S_DAT) || (state == S_CHK);

    // byte_ready tracks the next state: it defaults to "current state is an
    // accepting one" and is cleared explicitly on the transitions into DONE/ERR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_CNT;
            cnt        <= '0;
            chk        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            asm_word   <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            byte_ready <= active;
            if (accept) begin
                case (state)
                    S_CNT: begin
                        if ((byte_data == 8'd0) || (byte_data > DEPTH_B)) begin
                            state      <= S_ERR;
                            err        <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            cnt      <= byte_data;
                            chk      <= byte_data;
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= S_DAT;
                        end
                    end
                    S_DAT: begin
                        chk      <= chk ^ byte_data;
                        asm_word <= asm_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= asm_next;
                            word_idx  <= word_idx + 1'b1;
                            if (last_word) begin
                                state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        byte_ready <= 1'b0;
                        if (byte_data == chk) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Directed, table-driven bench for the instruction loader: frames go in as
// bytes, memory writes are captured and compared with hand-computed words.
module tb_cargador_instrucciones;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;
    int consec_we = 0;
    logic prev_we = 1'b0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    cargador_instrucciones #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk),
        .reset(reset),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_we && prev_we) consec_we++;
        prev_we = mem_we;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [7:0]  n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  chk;
        bit          bubbles;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] big_words[64];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one byte starting at a negedge; returns at the negedge right after acceptance.
    task automatic applyStimulus(input logic [7:0] b, input bit bubbles, output int waits);
        bit accepted = 1'b0;
        waits = 0;
        if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !accepted; t++) begin
            if (byte_ready) accepted = 1'b1;
            else waits++;
            @(negedge clk);
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL byte_accept: got not-accepted expected accepted (byte 0x%0h)", b);
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input bit bubbles, output int waits);
        int wt;
        waits = 0;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(w[i*8 +: 8], bubbles, wt);
            waits += wt;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {25'd0, byte_ready, mem_we, cpu_reset, done, err},
                    32'd0);
        checkOutput("reset_addr_data", {26'd0, mem_addr} | mem_wdata, 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, byte_ready}, 32'd1);
    endtask

    initial begin
        int w;
        int n_words;
        logic [7:0] c;
        vecs[0] = '{8'h01, 32'h20080005, 32'h0, 8'h2C, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{8'h00, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{8'h41, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h01, 32'h20080005, 32'h0, 8'h2D, 1'b0, 1'b0, 1'b1, 1};
        vecs[4] = '{8'h02, 32'h12345678, 32'hDEADBEEF, 8'h28, 1'b0, 1'b1, 1'b0, 2};
        vecs[5] = '{8'h02, 32'h12345678, 32'hDEADBEEF, 8'h28, 1'b1, 1'b1, 1'b0, 2};

        $display("[TB] starting table vectors");
        for (int v = 0; v < 6; v++) begin
            doReset();
            applyStimulus(vecs[v].n, vecs[v].bubbles, w);
            n_words = (vecs[v].n >= 8'd1 && vecs[v].n <= 8'd64) ? int'(vecs[v].n) : 0;
            if (n_words > 0) begin
                sendWord(vecs[v].w0, vecs[v].bubbles, w);
                if (n_words > 1) sendWord(vecs[v].w1, vecs[v].bubbles, w);
                applyStimulus(vecs[v].chk, vecs[v].bubbles, w);
            end
            byte_valid = 1'b0;
            checkOutput($sformatf("vec%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
            checkOutput($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
            checkOutput($sformatf("vec%0d_cpu_reset", v), {31'd0, cpu_reset}, {31'd0, vecs[v].exp_done});
            checkOutput($sformatf("vec%0d_ready_low", v), {31'd0, byte_ready}, 32'd0);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), vecs[v].exp_writes);
            for (int i = 0; i < wr_addr_q.size() && i < vecs[v].exp_writes; i++) begin
                checkOutput($sformatf("vec%0d_addr%0d", v, i), {26'd0, wr_addr_q[i]}, i);
                checkOutput($sformatf("vec%0d_data%0d", v, i), wr_data_q[i],
                            (i == 0) ? vecs[v].w0 : vecs[v].w1);
            end
        end

        $display("[TB] full 64-word frame");
        doReset();
        c = 8'h40;
        for (int i = 0; i < 64; i++) begin
            big_words[i] = $urandom;
            c = c ^ big_words[i][31:24] ^ big_words[i][23:16] ^ big_words[i][15:8] ^ big_words[i][7:0];
        end
        begin
            int gaps = 0;
            applyStimulus(8'h40, 1'b0, w);
            gaps += w;
            for (int i = 0; i < 64; i++) begin
                sendWord(big_words[i], 1'b0, w);
                gaps += w;
            end
            applyStimulus(c, 1'b0, w);
            gaps += w;
            checkOutput("full_no_gaps", gaps, 0);
        end
        checkOutput("full_done", {31'd0, done}, 32'd1);
        checkOutput("full_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("full_ready_low", {31'd0, byte_ready}, 32'd0);
        repeat (5) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        checkOutput("full_nwrites", wr_addr_q.size(), 64);
        begin
            int wrong = 0;
            for (int i = 0; i < wr_addr_q.size() && i < 64; i++) begin
                if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== big_words[i]) wrong++;
            end
            checkOutput("full_words", wrong, 0);
        end
        checkOutput("full_done_sticky", {30'd0, done, err}, 32'd2);

        $display("[TB] mid-frame reset");
        doReset();
        applyStimulus(8'h03, 1'b0, w);
        sendWord(32'hA1B2C3D4, 1'b0, w);
        applyStimulus(8'h55, 1'b0, w);
        applyStimulus(8'h66, 1'b0, w);
        reset = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0)
            checkOutput("midreset_word0", wr_data_q[0], 32'hA1B2C3D4);
        checkOutput("midreset_cleared", {29'd0, done, err, byte_ready}, 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(8'h01, 1'b0, w);
        sendWord(32'h20080005, 1'b0, w);
        applyStimulus(8'h2C, 1'b0, w);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_new_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            checkOutput("midreset_new_addr", {26'd0, wr_addr_q[0]}, 32'd0);
            checkOutput("midreset_new_data", wr_data_q[0], 32'h20080005);
        end
        checkOutput("midreset_done", {30'd0, done, err}, 32'd2);

        checkOutput("no_consecutive_we", consec_we, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
